eq_fir_mac: RTL and testbench

Sequential 16-tap FIR/equalizer stage sitting directly downstream of the 16-sample ADC history shift register in the pedal equalizer path. On each ready pulse it snapshots the 16 offset-binary 8-bit samples and runs one signed multiply-accumulate per clock against a host-programmable coefficient set. It then produces one rounded, saturated 8-bit offset-binary output sample for the DAC/output stage.

---
 rtl/eq_fir_mac_pkg.sv | 43 ++++
 rtl/eq_fir_mac_if.sv | 25 ++
 rtl/eq_fir_mac_coef_bank.sv | 45 ++++
 rtl/eq_fir_mac.sv | 122 ++++++++++++
 tb/tb_eq_fir_mac.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/eq_fir_mac_pkg.sv
// Shared constants, FSM state type and sample/arithmetic helpers for the
// 16-tap pedal equalizer FIR stage.
package eq_pkg;

   localparam int N_TAPS = 16;
   localparam int COEF_W = 12;
   localparam int FRAC   = 10;
   localparam int ACC_W  = 24;
   localparam int IDX_W  = 4;
   localparam int PROD_W = 8 + COEF_W;

   // Unity gain in the coefficient format, and the half-LSB used for rounding.
   localparam logic signed [COEF_W-1:0] COEF_ONE   = 12'sd1024;
   localparam logic signed [ACC_W-1:0]  ROUND_HALF = 24'sd512;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Offset-binary ADC code to two's complement.
   function automatic logic signed [7:0] off_to_s(input logic [7:0] t);
      return {~t[7], t[6:0]};
   endfunction

   // Two's complement back to offset-binary DAC code.
   function automatic logic [7:0] s_to_off(input logic signed [7:0] r);
      return {~r[7], r[6:0]};
   endfunction

   // Clamp a shifted accumulator value into the signed 8-bit range.
   function automatic logic signed [7:0] sat8(input logic signed [ACC_W-1:0] v);
      if (v > 24'sd127) begin
         return 8'sd127;
      end else if (v < -24'sd128) begin
         return 8'sh80;
      end else begin
         return v[7:0];
      end
   endfunction

endpackage

// File: rtl/eq_fir_mac_if.sv
// Sample/coefficient/result bundle between the history shifter, host and FIR stage.
interface eq_fir_mac_if;
   import eq_pkg::*;

   logic                     in_valid;
   logic [7:0]               tap [N_TAPS];
   logic                     coef_we;
   logic [IDX_W-1:0]         coef_addr;
   logic signed [COEF_W-1:0] coef_data;
   logic [7:0]               dout;
   logic                     out_valid;
   logic                     busy;
   logic                     overrun;

   modport master (
      output in_valid, tap, coef_we, coef_addr, coef_data,
      input  dout, out_valid, busy, overrun
   );

   modport slave (
      input  in_valid, tap, coef_we, coef_addr, coef_data,
      output dout, out_valid, busy, overrun
   );

endinterface

// File: rtl/eq_fir_mac_coef_bank.sv
// Double-buffered coefficient store: the host writes the staging bank at any
// time, the active bank is refreshed only when a frame is accepted.
module fir_coef_bank
   import eq_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we_i,
   input  logic [IDX_W-1:0]         addr_i,
   input  logic signed [COEF_W-1:0] data_i,
   input  logic                     accept_i,
   input  logic [IDX_W-1:0]         rd_idx_i,
   output logic signed [COEF_W-1:0] c_act_o
);

   logic signed [COEF_W-1:0] stg_q [N_TAPS];
   logic signed [COEF_W-1:0] act_q [N_TAPS];

   // Staging bank: host write port, identity after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_TAPS; i++) begin
            stg_q[i] <= (i == 0) ? COEF_ONE : 12'sd0;
         end
      end else if (we_i) begin
         stg_q[addr_i] <= data_i;
      end
   end

   // Active bank: snapshot of staging on accept; a same-cycle write is forwarded.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_TAPS; i++) begin
            act_q[i] <= (i == 0) ? COEF_ONE : 12'sd0;
         end
      end else if (accept_i) begin
         for (int i = 0; i < N_TAPS; i++) begin
            act_q[i] <= (we_i && (addr_i == 4'(i))) ? data_i : stg_q[i];
         end
      end
   end

   assign c_act_o = act_q[rd_idx_i];

endmodule

// File: rtl/eq_fir_mac.sv
// Sequential 16-tap FIR: snapshot taps on in_valid, one MAC per clock,
// then round, saturate and emit one offset-binary sample.
module eq_fir_mac
   import eq_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   eq_fir_mac_if.slave bus
);

   state_e                   state_q;
   logic [IDX_W-1:0]         idx_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic [7:0]               snap_q [N_TAPS];
   logic [7:0]               dout_q;
   logic                     out_valid_q;
   logic                     busy_q;
   logic                     overrun_q;

   logic                     accept_s;
   logic signed [COEF_W-1:0] c_act_s;
   logic signed [7:0]        samp_s;
   logic signed [PROD_W-1:0] samp_ext_s;
   logic signed [PROD_W-1:0] coef_ext_s;
   logic signed [PROD_W-1:0] prod_s;
   logic signed [ACC_W-1:0]  prod_ext_s;
   logic signed [ACC_W-1:0]  rnd_sum_s;
   logic signed [ACC_W-1:0]  shifted_s;
   logic [7:0]               dout_d;

   fir_coef_bank u_coef_bank (
      .clk      (clk),
      .reset    (reset),
      .we_i     (bus.coef_we),
      .addr_i   (bus.coef_addr),
      .data_i   (bus.coef_data),
      .accept_i (accept_s),
      .rd_idx_i (idx_q),
      .c_act_o  (c_act_s)
   );

   // A new frame is taken only when no accumulation is in flight.
   always_comb begin
      accept_s = 1'b0;
      if (bus.in_valid && ((state_q == IDLE) || (state_q == DONE))) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

   // Product of the current tap and coefficient, plus the round/saturate of the final sum.
   always_comb begin
      samp_s     = off_to_s(snap_q[idx_q]);
      samp_ext_s = {{(PROD_W-8){samp_s[7]}}, samp_s};
      coef_ext_s = {{(PROD_W-COEF_W){c_act_s[COEF_W-1]}}, c_act_s};
      prod_s     = samp_ext_s * coef_ext_s;
      prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
      rnd_sum_s  = acc_q + ROUND_HALF;
      shifted_s  = rnd_sum_s >>> FRAC;
      dout_d     = s_to_off(sat8(shifted_s));
   end

   // Frame FSM with registered outputs; acceptance overrides the DONE->IDLE return.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= 4'd0;
         acc_q       <= 24'sd0;
         dout_q      <= 8'h80;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         for (int i = 0; i < N_TAPS; i++) begin
            snap_q[i] <= 8'h80;
         end
      end else begin
         out_valid_q <= 1'b0;
         if (bus.in_valid && (state_q == MAC)) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               busy_q <= 1'b0;
            end
            MAC: begin
               acc_q <= acc_q + prod_ext_s;
               if (idx_q == 4'd15) begin
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + 4'd1;
               end
            end
            DONE: begin
               dout_q      <= dout_d;
               out_valid_q <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
         if (accept_s) begin
            for (int i = 0; i < N_TAPS; i++) begin
               snap_q[i] <= bus.tap[i];
            end
            acc_q   <= 24'sd0;
            idx_q   <= 4'd0;
            busy_q  <= 1'b1;
            state_q <= MAC;
         end
      end
   end

   assign bus.dout      = dout_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_eq_fir_mac.sv
// Scoreboard bench for eq_fir_mac: expected samples are queued at stimulus
// time from an integer reference model and popped when out_valid fires.
module tb_eq_fir_mac;
   import eq_pkg::*;

   typedef logic [7:0] taps_t [16];
   typedef struct {
      logic [7:0] dout;
      int         due;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   exp_t sb [$];
   int   stg_m [16];
   int   act_m [16];
   logic prev_ov = 1'b0;

   eq_fir_mac_if bus ();

   eq_fir_mac dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Free-running cycle count used to time out_valid.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference: integer dot product, floor((sum+512)/1024), clamp, re-bias.
   function automatic logic [7:0] model(input taps_t t, input int c [16]);
      int sum;
      int q;
      sum = 0;
      for (int i = 0; i < 16; i++) sum += (int'(t[i]) - 128) * c[i];
      sum += 512;
      if (sum >= 0) q = sum / 1024;
      else          q = -((-sum + 1023) / 1024);
      if (q > 127)  q = 127;
      if (q < -128) q = -128;
      return 8'(q + 128);
   endfunction

   // Output monitor: pops the scoreboard and checks value, latency and pulse width.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset) begin
         check_val("ov_consecutive", {31'd0, prev_ov & bus.out_valid}, 32'd0);
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               check_val("ov_unexpected", {31'd0, bus.out_valid}, 32'd0);
            end else begin
               e = sb.pop_front();
               check_val("dout", {24'd0, bus.dout}, {24'd0, e.dout});
               check_val("latency", cyc, e.due);
            end
         end
      end
      prev_ov = bus.out_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_identity();
      for (int i = 0; i < 16; i++) begin
         stg_m[i] = (i == 0) ? 1024 : 0;
         act_m[i] = stg_m[i];
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      sb.delete();
      model_identity();
   endtask

   task automatic write_coef(input int a, input int d);
      bus.coef_we   = 1'b1;
      bus.coef_addr = 4'(a);
      bus.coef_data = 12'(d);
      stg_m[a]      = d;
      tick();
      bus.coef_we   = 1'b0;
   endtask

   // Drive one in_valid; optional coefficient write in the same cycle.
   task automatic send(input taps_t t, input bit accepted, input bit we, input int wa, input int wd);
      exp_t e;
      for (int i = 0; i < 16; i++) bus.tap[i] = t[i];
      bus.in_valid = 1'b1;
      if (we) begin
         bus.coef_we   = 1'b1;
         bus.coef_addr = 4'(wa);
         bus.coef_data = 12'(wd);
         stg_m[wa]     = wd;
      end
      if (accepted) begin
         for (int i = 0; i < 16; i++) act_m[i] = stg_m[i];
         e.dout = model(t, act_m);
         e.due  = cyc + 18;
         sb.push_back(e);
      end
      tick();
      bus.in_valid = 1'b0;
      bus.coef_we  = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 80 && sb.size() != 0; i++) tick();
      check_val("drain", sb.size(), 32'd0);
      tick();
      tick();
   endtask

   task automatic rand_taps(output taps_t t);
      for (int i = 0; i < 16; i++) t[i] = 8'($urandom_range(0, 255));
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      taps_t t;
      taps_t t2;
      bus.in_valid  = 1'b0;
      bus.coef_we   = 1'b0;
      bus.coef_addr = 4'd0;
      bus.coef_data = 12'sd0;
      for (int i = 0; i < 16; i++) bus.tap[i] = 8'h00;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      model_identity();

      // Reset state
      @(negedge clk);
      check_val("rst_dout", {24'd0, bus.dout}, 32'h80);
      check_val("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
      check_val("rst_overrun", {31'd0, bus.overrun}, 32'd0);
      tick();

      // Identity after reset, with busy profile
      rand_taps(t);
      t[0] = 8'hC8;
      send(t, 1'b1, 1'b0, 0, 0);
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         check_val("busy_high", {31'd0, bus.busy}, 32'd1);
      end
      @(negedge clk);
      check_val("busy_low", {31'd0, bus.busy}, 32'd0);
      drain();

      // Averaging
      for (int i = 0; i < 16; i++) write_coef(i, 64);
      for (int i = 0; i < 16; i++) t[i] = 8'h90;
      send(t, 1'b1, 1'b0, 0, 0);
      drain();
      for (int i = 0; i < 16; i++) t[i] = ((i % 2) == 0) ? 8'hFF : 8'h01;
      send(t, 1'b1, 1'b0, 0, 0);
      drain();

      // Rounding half toward +inf
      write_coef(0, 512);
      for (int i = 1; i < 16; i++) write_coef(i, 0);
      rand_taps(t);
      t[0] = 8'h83;
      send(t, 1'b1, 1'b0, 0, 0);
      drain();

      // Saturation both ways
      for (int i = 0; i < 16; i++) write_coef(i, 2047);
      for (int i = 0; i < 16; i++) t[i] = 8'hFF;
      send(t, 1'b1, 1'b0, 0, 0);
      drain();
      for (int i = 0; i < 16; i++) t[i] = 8'h00;
      send(t, 1'b1, 1'b0, 0, 0);
      drain();

      // Overrun: second in_valid 5 clocks after accept is dropped
      do_reset();
      rand_taps(t);
      rand_taps(t2);
      send(t, 1'b1, 1'b0, 0, 0);
      repeat (4) tick();
      send(t2, 1'b0, 1'b0, 0, 0);
      drain();
      repeat (20) tick();
      @(negedge clk);
      check_val("overrun_sticky", {31'd0, bus.overrun}, 32'd1);
      tick();

      // Back-to-back: second frame lands in DONE, 17 clocks after accept
      rand_taps(t);
      rand_taps(t2);
      send(t, 1'b1, 1'b0, 0, 0);
      repeat (16) tick();
      send(t2, 1'b1, 1'b0, 0, 0);
      drain();

      // Same-cycle coefficient write is included in the copy
      do_reset();
      rand_taps(t);
      send(t, 1'b1, 1'b1, 1, 1024);
      drain();

      // Coefficient isolation: mid-frame write only affects the next frame
      do_reset();
      rand_taps(t);
      send(t, 1'b1, 1'b0, 0, 0);
      repeat (3) tick();
      write_coef(0, 0);
      drain();
      rand_taps(t2);
      send(t2, 1'b1, 1'b0, 0, 0);
      drain();

      // Reset mid-frame at E8 aborts and restores identity
      do_reset();
      write_coef(0, 0);
      write_coef(3, 300);
      rand_taps(t);
      send(t, 1'b1, 1'b0, 0, 0);
      repeat (7) tick();
      reset = 1'b1;
      sb.delete();
      tick();
      reset = 1'b0;
      model_identity();
      @(negedge clk);
      check_val("midrst_busy", {31'd0, bus.busy}, 32'd0);
      check_val("midrst_overrun", {31'd0, bus.overrun}, 32'd0);
      check_val("midrst_dout", {24'd0, bus.dout}, 32'h80);
      repeat (25) tick();
      rand_taps(t);
      t[0] = 8'h5A;
      send(t, 1'b1, 1'b0, 0, 0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
